// File: rtl/arbitro_pkg.sv
// arbitro_pkg: opcodes and FSM states shared by the vector-operation arbiter
package arbitro_pkg;

    localparam logic [1:0] OP_OR_BIT  = 2'b00;
    localparam logic [1:0] OP_OR_LOG  = 2'b01;
    localparam logic [1:0] OP_NOT_CAT = 2'b10;
    localparam logic [1:0] OP_ILEGAL  = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO,
        EXECUTA,
        ENTREGA
    } estado_t;

endpackage

// File: rtl/arbitro_rr.sv
// arbitro_rr: two-input round-robin grant, the pointer picks the winner on ties
module arbitro_rr (
    input  logic [1:0] req,
    input  logic       pointer,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_idx
);

    // a lone requester always wins; with both asserted the pointer decides
    always_comb begin
        grant     = !enable ? 2'b00 : (req == 2'b11) ? (pointer ? 2'b10 : 2'b01) : req;
        grant_idx = grant[1];
    end

endmodule

// File: rtl/arbitro_operacoes.sv
// arbitro_operacoes: shares one vector-logic unit between two requesters in round-robin order
module arbitro_operacoes
    import arbitro_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [WIDTH-1:0]   req_a0,
    input  logic [WIDTH-1:0]   req_b0,
    input  logic [WIDTH-1:0]   req_a1,
    input  logic [WIDTH-1:0]   req_b1,
    input  logic [1:0]         req_op0,
    input  logic [1:0]         req_op1,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic               res_id,
    output logic               res_erro,
    output logic [CNT_W-1:0]   total_ops
);

    estado_t              state_q;
    logic                 ptr_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [1:0]           op_q;
    logic                 id_q;
    logic [2*WIDTH-1:0]   res_data_q, res_data_d;
    logic                 res_erro_q, res_erro_d;
    logic [CNT_W-1:0]     total_q;
    logic [1:0]           grant;
    logic                 grant_idx;

    arbitro_rr u_rr (
        .req       (req_valid),
        .pointer   (ptr_q),
        .enable    (state_q == OCIOSO),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // operation unit evaluated on the latched request
    always_comb begin
        res_data_d = (op_q == OP_OR_BIT)  ? {{WIDTH{1'b0}}, a_q | b_q} :
                     (op_q == OP_OR_LOG)  ? {{(2*WIDTH-1){1'b0}}, (|a_q) || (|b_q)} :
                     (op_q == OP_NOT_CAT) ? ~{b_q, a_q} : '0;
        res_erro_d = (op_q == OP_ILEGAL);
    end

    // accept, execute and deliver; reset discards any in-flight result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OCIOSO;
            ptr_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            id_q       <= 1'b0;
            res_data_q <= '0;
            res_erro_q <= 1'b0;
            total_q    <= '0;
        end else begin
            case (state_q)
                OCIOSO: if (|grant) begin
                    a_q     <= grant_idx ? req_a1 : req_a0;
                    b_q     <= grant_idx ? req_b1 : req_b0;
                    op_q    <= grant_idx ? req_op1 : req_op0;
                    id_q    <= grant_idx;
                    ptr_q   <= !grant_idx;
                    state_q <= EXECUTA;
                end
                EXECUTA: begin
                    res_data_q <= res_data_d;
                    res_erro_q <= res_erro_d;
                    state_q    <= ENTREGA;
                end
                ENTREGA: if (res_ready) begin
                    total_q <= total_q + 1'b1;
                    state_q <= OCIOSO;
                end
                default: state_q <= OCIOSO;
            endcase
        end
    end

    assign req_ready = grant;
    assign res_valid = (state_q == ENTREGA);
    assign res_data  = res_data_q;
    assign res_id    = id_q;
    assign res_erro  = res_erro_q;
    assign total_ops = total_q;

endmodule

// File: tb/tb_arbitro_operacoes.sv
// tb_arbitro_operacoes: directed vectors and corner sequences for the operation arbiter
module tb_arbitro_operacoes;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [2:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0] req_op0 = '0, req_op1 = '0;
    logic       res_ready = 1'b0;

    logic [1:0] req_ready, req_ready2;
    logic       res_valid, res_valid2, res_id, res_id2, res_erro, res_erro2;
    logic [5:0] res_data, res_data2;
    logic [7:0] total_ops;
    logic [1:0] total_ops2;

    int checks = 0;
    int errors = 0;
    int count  = 0;

    always #5 clk = ~clk;

    arbitro_operacoes #(.WIDTH(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .res_erro(res_erro), .total_ops(total_ops)
    );

    arbitro_operacoes #(.WIDTH(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .res_valid(res_valid2), .res_ready(res_ready),
        .res_data(res_data2), .res_id(res_id2), .res_erro(res_erro2), .total_ops(total_ops2)
    );

    typedef struct {
        logic       id;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] op;
        logic [5:0] exp_data;
        logic       exp_erro;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        @(negedge clk);
        res_ready = 1'b1;
        if (v.id) begin req_a1 = v.a; req_b1 = v.b; req_op1 = v.op; end
        else begin req_a0 = v.a; req_b0 = v.b; req_op0 = v.op; end
        req_valid = v.id ? 2'b10 : 2'b01;
        #1 chk("grant", req_ready, v.id ? 2 : 1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("exec_no_valid", res_valid, 0);
        chk("exec_no_ready", req_ready, 0);
        @(negedge clk);
        chk("valid_t2", res_valid, 1);
        chk("data", res_data, v.exp_data);
        chk("id", res_id, v.id);
        chk("erro", res_erro, v.exp_erro);
        @(negedge clk);
        count++;
        chk("valid_drop", res_valid, 0);
        chk("total", total_ops, count);
        chk("total_w2", total_ops2, count % 4);
    endtask

    initial begin
        vecs[0] = '{1'b0, 3'b101, 3'b010, 2'b00, 6'b000111, 1'b0};
        vecs[1] = '{1'b1, 3'b000, 3'b000, 2'b01, 6'b000000, 1'b0};
        vecs[2] = '{1'b1, 3'b000, 3'b100, 2'b01, 6'b000001, 1'b0};
        vecs[3] = '{1'b1, 3'b001, 3'b110, 2'b10, 6'b001110, 1'b0};
        vecs[4] = '{1'b1, 3'b111, 3'b111, 2'b11, 6'b000000, 1'b1};
        vecs[5] = '{1'b0, 3'b011, 3'b100, 2'b10, 6'b011100, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_valid", res_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data", res_data, 0);
        chk("rst_total", total_ops, 0);
        rst = 1'b0;

        res_ready = 1'b1;
        @(negedge clk);
        chk("ready_idle_ignored", total_ops, 0);

        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        // reset while a result is waiting in delivery
        @(negedge clk);
        res_ready = 1'b0;
        req_a0 = 3'b111; req_b0 = 3'b000; req_op0 = 2'b00;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("pre_rst_valid", res_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", res_valid, 0);
        chk("async_rst_ready", req_ready, 0);
        chk("async_rst_data", res_data, 0);
        chk("async_rst_total", total_ops, 0);
        chk("async_rst_total_w2", total_ops2, 0);
        @(negedge clk);
        rst = 1'b0;
        count = 0;

        // continuous contention from pointer 0
        req_a0 = 3'b001; req_b0 = 3'b010; req_op0 = 2'b00;
        req_a1 = 3'b101; req_b1 = 3'b101; req_op1 = 2'b11;
        res_ready = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int t = 0;
            #1;
            while (req_ready == 2'b00 && t < 10) begin @(negedge clk); #1; t++; end
            chk("cont_grant", req_ready, (k % 2) ? 2 : 1);
            t = 0;
            @(negedge clk);
            while (!res_valid && t < 10) begin @(negedge clk); t++; end
            chk("cont_id", res_id, k % 2);
            chk("cont_data", res_data, (k % 2) ? 6'b000000 : 6'b000011);
            chk("cont_erro", res_erro, k % 2);
            @(negedge clk);
            count++;
        end
        req_valid = 2'b00;
        chk("cont_total", total_ops, 4);

        // backpressure: result must hold while requester 1 keeps asking
        @(negedge clk);
        res_ready = 1'b0;
        req_a0 = 3'b100; req_b0 = 3'b001; req_op0 = 2'b00;
        req_valid = 2'b01;
        #1 chk("bp_grant", req_ready, 1);
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 6'b000101);
            chk("bp_no_ready", req_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        count++;
        chk("bp_delivered", res_valid, 0);
        chk("bp_next_accept", req_ready, 2);
        chk("bp_total", total_ops, count);
        chk("wrap_total", total_ops2, 1);
        req_valid = 2'b00;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_operacoes.md
# arbitro_operacoes

Round-robin controller that shares a single vector-logic unit between two requesters. Each requester submits a pair of WIDTH-bit vectors plus an opcode (bitwise OR, logical OR, NOT of the concatenation). The block grants one request at a time, sequences it through a registered execute stage, and holds the tagged result on a valid/ready output until it is consumed. It sits between the requesting logic and any downstream consumer, such as a display driver or a scoreboard.

## Interface
- WIDTH, 3: width of each operand vector; the result is 2*WIDTH bits.
- CNT_W, 8: width of the completed-operation counter.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; at most one bit high.
- req_a0, req_b0  in  WIDTH each  operands of requester 0.
- req_a1, req_b1  in  WIDTH each  operands of requester 1.
- req_op0, req_op1  in  2 each  opcode of requester 0 / 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  2*WIDTH  result, zero-extended as defined below.
- res_id  out  1  index of the requester that produced the result.
- res_erro  out  1  result came from an illegal opcode.
- total_ops  out  CNT_W  count of delivered results.

## Operation
- FSM states: OCIOSO, EXECUTA, ENTREGA.
- **OCIOSO**
  - The arbiter grants among the asserted req_valid bits. The requester indicated by the priority pointer wins ties; a lone requester always wins.
  - req_ready[g] = 1 combinationally for granted g only when state == OCIOSO; otherwise req_ready = 0.
  - On the handshake, latch operands, opcode and g; flip the pointer to !g; go to EXECUTA.
- **EXECUTA**
  - Compute the result into the result register, set res_erro for an illegal opcode, and go to ENTREGA. Lasts exactly one cycle.
- **ENTREGA**
  - res_valid = 1. res_data, res_id and res_erro are held stable while res_valid && !res_ready.
  - On res_ready: increment total_ops (wraps from 2^CNT_W-1 to 0) and go to OCIOSO.
- Opcodes:
  - 00: res_data = {WIDTH zeros, a | b}.
  - 01: res_data = {zeros, ((a != 0) || (b != 0))} (bit 0 only).
  - 10: res_data = ~{b, a}.
  - 11: res_data = 0 and res_erro = 1.
- Width rules:
  - All zero-extension is on the MSB side.
  - {b, a} places b in the upper WIDTH bits.
- Requests arriving outside OCIOSO are not accepted. A requester must hold valid and its inputs until it sees its ready bit.

## Timing
- Reset values:
  - state = OCIOSO, pointer = 0, req_ready = 0.
  - res_valid = 0, res_data = 0, res_id = 0, res_erro = 0, total_ops = 0.
- Handshake at edge T → EXECUTA during T+1 → res_valid high from T+2.
- Minimum period between accepts is 3 cycles, reached when res_ready is held high.
- Next accept is possible in the cycle after the result handshake. There is no accept in the same cycle as delivery.
- Both requesters valid with pointer = 0: requester 0 is granted, then requester 1. Continuous contention alternates 0,1,0,1.
- rst asserted mid-operation: all state clears immediately (asynchronous), and the in-flight result is discarded and not counted. After deassertion, the block restarts in OCIOSO with pointer 0.
- res_ready asserted while res_valid = 0 is ignored.

## Structure
- Shared package arbitro_pkg:
  - opcode constants OP_OR_BIT = 2'b00, OP_OR_LOG = 2'b01, OP_NOT_CAT = 2'b10.
  - state enum {OCIOSO, EXECUTA, ENTREGA}.
- Sub-module arbitro_rr: 2-input round-robin grant.
  - Inputs: req[1:0], pointer, enable.
  - Outputs: grant[1:0] (one-hot or zero) and grant index.
  - Pointer update stays in the parent.
- Operation datapath and FSM live in the parent.

## Test plan
- Reset: apply rst mid-run → all outputs 0 and req_ready = 0 within the same cycle; total_ops = 0.
- Single op 00: requester 0, a=3'b101, b=3'b010, res_ready=1 → res_valid at T+2, res_data=6'b000111, res_id=0, res_erro=0, total_ops=1.
- Ops 01/10/11 from requester 1:
  - a=0, b=0, op=01 → res_data=0.
  - a=0, b=3'b100, op=01 → res_data=6'b000001.
  - a=3'b001, b=3'b110, op=10 → res_data=6'b001110.
  - op=11 → res_data=0, res_erro=1.
- Contention: both requesters valid continuously for 4 ops → res_id sequence 0,1,0,1, with exactly one req_ready bit per accept.
- Backpressure: hold res_ready=0 for 5 cycles in ENTREGA → res_data stable and no new req_ready. Release → delivery, then accept on the following cycle.
- Counter wrap: CNT_W=2, 5 completed ops → total_ops = 1.
